// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// latency helper and divide-by-zero result constants.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // PREP + FIX + DONE on top of one ITER cycle per quotient bit
    localparam int LAT_OVERHEAD = 3;

    localparam logic DBZ_FLAG      = 1'b1;
    localparam logic DBZ_QUOT_FILL = 1'b0;

    function automatic int div_latency(input int width);
        return width + LAT_OVERHEAD;
    endfunction

endpackage

// File: rtl/seq_divider_sub_cla4.sv
// 4-bit borrow-lookahead subtract slice: diff = a - b - bin, with group
// propagate/generate so slices can be chained by lookahead.
module sub_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout,
    output logic       gp,
    output logic       gg
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] bi_s;

    // bit i borrows when a=0,b=1; passes an incoming borrow when a==b
    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    assign bi_s[0] = bin;
    assign bi_s[1] = g_s[0] | (p_s[0] & bin);
    assign bi_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign bi_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                   | (p_s[2] & p_s[1] & p_s[0] & bin);

    assign diff = a ^ b ^ bi_s;
    assign gp   = &p_s;
    assign gg   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign bout = gg | (gp & bin);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour the Signed input (two's-complement divide).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam int NS = (WIDTH + 4) / 4;
    localparam int PW = NS * 4;

    div_state_t       state_r, state_n;
    logic [WIDTH-1:0] dvd_r, dsr_r, rem_r, quo_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic [CW-1:0]    cnt_r;
    logic             sgn_r, neg_q_r, neg_r_r;
    logic             busy_r, done_r, dbz_r;

    logic [WIDTH:0]   shifted_s;
    logic [PW-1:0]    op_a_s, op_b_s, diff_s;
    logic [NS-1:0]    bout_s;
    logic             borrow_s, dsr_zero_s, unused_s;

    assign shifted_s  = {rem_r, dvd_r[WIDTH-1]};
    assign op_a_s     = PW'(shifted_s);
    assign op_b_s     = PW'({1'b0, dsr_r});
    assign dsr_zero_s = (dsr_r == {WIDTH{1'b0}});

    // trial subtractor, slices chained through group propagate/generate
    for (genvar k = 0; k < NS; k++) begin : g_slice
        logic bin_k, gp_k, gg_k, bout_grp;
        if (k == 0) begin : g_first
            assign bin_k = 1'b0;
        end else begin : g_next
            assign bin_k = g_slice[k-1].bout_grp;
        end
        sub_cla4 u_slice (
            .a    (op_a_s[4*k +: 4]),
            .b    (op_b_s[4*k +: 4]),
            .bin  (bin_k),
            .diff (diff_s[4*k +: 4]),
            .bout (bout_s[k]),
            .gp   (gp_k),
            .gg   (gg_k)
        );
        assign bout_grp = gg_k | (gp_k & bin_k);
    end

    assign borrow_s = g_slice[NS-1].bout_grp;

`ifdef DIV_SIGNED_EN
    assign unused_s = ^{bout_s, diff_s[PW-1:WIDTH]};
`else
    assign unused_s = ^{bout_s, diff_s[PW-1:WIDTH], Signed};
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (Reset) state_r <= ST_IDLE;
        else       state_r <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: if (Start)        state_n = ST_PREP; else state_n = ST_IDLE;
            ST_PREP: if (dsr_zero_s)   state_n = ST_DONE; else state_n = ST_ITER;
            ST_ITER: if (cnt_r == {CW{1'b0}}) state_n = ST_FIX; else state_n = ST_ITER;
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // operand capture, iteration datapath and registered results
    always_ff @(posedge CLK) begin
        if (Reset) begin
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            sgn_r       <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_n == ST_PREP) || (state_n == ST_ITER) || (state_n == ST_FIX);
            done_r <= (state_n == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        dvd_r <= Dividend;
                        dsr_r <= Divisor;
`ifdef DIV_SIGNED_EN
                        sgn_r <= Signed;
`else
                        sgn_r <= 1'b0;
`endif
                    end
                end
                ST_PREP: begin
                    if (dsr_zero_s) begin
                        quotient_r  <= {WIDTH{DBZ_QUOT_FILL}};
                        remainder_r <= dvd_r;
                        dbz_r       <= DBZ_FLAG;
                    end else begin
`ifdef DIV_SIGNED_EN
                        // most-negative operand negates to itself, read as unsigned 2^(WIDTH-1)
                        if (sgn_r) begin
                            if (dvd_r[WIDTH-1]) dvd_r <= {WIDTH{1'b0}} - dvd_r;
                            if (dsr_r[WIDTH-1]) dsr_r <= {WIDTH{1'b0}} - dsr_r;
                            neg_q_r <= dvd_r[WIDTH-1] ^ dsr_r[WIDTH-1];
                            neg_r_r <= dvd_r[WIDTH-1];
                        end else begin
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                        end
`else
                        neg_q_r <= 1'b0;
                        neg_r_r <= 1'b0;
`endif
                        rem_r <= {WIDTH{1'b0}};
                        quo_r <= {WIDTH{1'b0}};
                        cnt_r <= CW'(WIDTH - 1);
                    end
                end
                ST_ITER: begin
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    rem_r <= borrow_s ? shifted_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], ~borrow_s};
                    cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    quotient_r  <= neg_q_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
                    remainder_r <= neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
                    dbz_r       <= 1'b0;
                end
                ST_DONE: begin
                    dbz_r <= dbz_r;
                end
                default: begin
                    dbz_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Quotient  = quotient_r;
    assign Remainder = remainder_r;
    assign DivByZero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); expectations
// follow the build, so signed vectors expect unsigned results unless DIV_SIGNED_EN.
module tb_seq_divider;

    logic        CLK = 1'b0;
    logic        Reset, Start, Signed;
    logic [31:0] Dividend, Divisor;
    logic        Busy, Done, DivByZero;
    logic [31:0] Quotient, Remainder;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Start a divide, optionally poke a second Start at cycle poke_cyc, and check everything
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input int poke_cyc, input logic [31:0] q_exp,
                           input logic [31:0] r_exp, input logic z_exp, input int lat_exp);
        int done_cyc;
        int busy_err;
        Start = 1'b1; Dividend = a; Divisor = b; Signed = sg;
        tick();
        Start = 1'b0;
        done_cyc = -1;
        busy_err = 0;
        for (int k = 1; k <= 60; k++) begin
            if (Busy !== (k < lat_exp)) busy_err++;
            if (Done === 1'b1) begin
                done_cyc = k;
                break;
            end
            if (k == poke_cyc) begin
                Start = 1'b1; Dividend = 32'd9; Divisor = 32'd3; Signed = 1'b0;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Start = 1'b0;
        check_val({tag, "_done_cycle"}, done_cyc, lat_exp);
        check_val({tag, "_busy_errs"}, busy_err, 32'd0);
        check_val({tag, "_quot"}, Quotient, q_exp);
        check_val({tag, "_rem"}, Remainder, r_exp);
        check_val({tag, "_dbz"}, {31'd0, DivByZero}, {31'd0, z_exp});
        tick();
        check_val({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        check_val({tag, "_quot_held"}, Quotient, q_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0;
        Dividend = 32'd0; Divisor = 32'd0;
        tick(); tick();
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_done", {31'd0, Done}, 32'd0);
        check_val("rst_quot", Quotient, 32'd0);
        check_val("rst_rem", Remainder, 32'd0);
        check_val("rst_dbz", {31'd0, DivByZero}, 32'd0);
        Reset = 1'b0;
        tick();

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 35);
        run_div("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'h7FFF_FFFC, 32'd1, 1'b0, 35);
        run_div("u_ffff_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd1, 32'd0, 1'b0, 35);
        run_div("u_big_div", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 32'd1, 32'h7FFF_FFFE, 1'b0, 35);
        run_div("u_dbz", 32'd5, 32'd0, 1'b0, 0, 32'd0, 32'd5, 1'b1, 2);
        run_div("s_dbz", 32'd5, 32'd0, 1'b1, 0, 32'd0, 32'd5, 1'b1, 2);
`ifdef DIV_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35);
        run_div("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 35);
`else
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'h7FFF_FFFC, 32'd1, 1'b0, 35);
        run_div("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 32'h2492_4916, 32'd2, 1'b0, 35);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'd0, 32'h8000_0000, 1'b0, 35);
`endif
        run_div("ignored_start", 32'd100, 32'd7, 1'b0, 5, 32'd14, 32'd2, 1'b0, 35);

        // reset in the middle of an iteration
        Start = 1'b1; Dividend = 32'd100; Divisor = 32'd7; Signed = 1'b0;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check_val("mid_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_val("mrst_busy", {31'd0, Busy}, 32'd0);
        check_val("mrst_done", {31'd0, Done}, 32'd0);
        check_val("mrst_quot", Quotient, 32'd0);
        check_val("mrst_rem", Remainder, 32'd0);
        check_val("mrst_dbz", {31'd0, DivByZero}, 32'd0);
        run_div("after_rst_9_3", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
